// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: memory-control encodings, FSM
// states and the legality/alignment checks applied at issue.
package lsu_pkg;

    localparam logic [2:0] MEM_LB  = 3'b000;
    localparam logic [2:0] MEM_LH  = 3'b001;
    localparam logic [2:0] MEM_LW  = 3'b010;
    localparam logic [2:0] MEM_LBU = 3'b011;
    localparam logic [2:0] MEM_LHU = 3'b100;
    localparam logic [2:0] MEM_SB  = 3'b101;
    localparam logic [2:0] MEM_SH  = 3'b110;
    localparam logic [2:0] MEM_SW  = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Stores must use the store encodings and loads the load encodings.
    function automatic logic legal(input logic we, input logic [2:0] ctrl);
        return we ? (ctrl >= MEM_SB) : (ctrl <= MEM_LHU);
    endfunction

    function automatic logic aligned(input logic [2:0] ctrl, input logic [1:0] off);
        logic ok;
        ok = 1'b1;
        case (ctrl)
            MEM_LH, MEM_LHU, MEM_SH: ok = (off[0] == 1'b0);
            MEM_LW, MEM_SW:          ok = (off == 2'b00);
            default:                 ok = 1'b1;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store byte enables / lane replication on the issue side,
// and lane extraction with sign/zero extension on the load-return side.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  st_ctrl,
    input  logic [1:0]  st_off,
    input  logic [31:0] st_data,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    input  logic [2:0]  ld_ctrl,
    input  logic [1:0]  ld_off,
    input  logic [31:0] ld_word,
    output logic [31:0] ld_data
);

    logic [7:0]  lane [4];
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign lane[gi] = ld_word[gi*8 +: 8];
        end
    endgenerate

    assign byte_sel = lane[ld_off];
    assign half_sel = ld_off[1] ? ld_word[31:16] : ld_word[15:0];

    always_comb begin
        be        = 4'b1111;
        wdata_rep = st_data;
        case (st_ctrl)
            MEM_SB: begin
                be        = 4'b0001 << st_off;
                wdata_rep = {4{st_data[7:0]}};
            end
            MEM_SH: begin
                be        = 4'b0011 << {st_off[1], 1'b0};
                wdata_rep = {2{st_data[15:0]}};
            end
            default: begin
                be        = 4'b1111;
                wdata_rep = st_data;
            end
        endcase
    end

    always_comb begin
        ld_data = 32'h0;
        case (ld_ctrl)
            MEM_LB:  ld_data = {{24{byte_sel[7]}}, byte_sel};
            MEM_LBU: ld_data = {24'h0, byte_sel};
            MEM_LH:  ld_data = {{16{half_sel[15]}}, half_sel};
            MEM_LHU: ld_data = {16'h0, half_sel};
            MEM_LW:  ld_data = ld_word;
            default: ld_data = 32'h0;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one req/ack data-memory transaction per instruction, with
// pipeline stall, fault reporting for illegal/misaligned accesses and timeout.
module lsu
    import lsu_pkg::*;
#(
    parameter int ACK_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid,
    input  logic        memRD,
    input  logic        memWR,
    input  logic [2:0]  memCtrl,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic        done,
    output logic [31:0] rdata,
    output logic        fault,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata
);

    localparam int CW = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;
    localparam bit TO_EN = (ACK_TIMEOUT > 0);
    localparam logic [CW-1:0] CNT_LAST = CW'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);

    state_t          state_reg;
    logic [2:0]      ctrl_reg;
    logic [1:0]      off_reg;
    logic [CW-1:0]   cnt_reg;

    logic            op;
    logic            issue_we;
    logic            issue_ok;
    logic [3:0]      be_comb;
    logic [31:0]     wrep_comb;
    logic [31:0]     ld_ext;

    assign op       = valid & (memRD | memWR);
    assign issue_we = memWR;
    assign issue_ok = legal(issue_we, memCtrl) & aligned(memCtrl, addr[1:0]);
    assign stall    = op & ~done;

    lsu_align u_align (
        .st_ctrl   (memCtrl),
        .st_off    (addr[1:0]),
        .st_data   (wdata),
        .be        (be_comb),
        .wdata_rep (wrep_comb),
        .ld_ctrl   (ctrl_reg),
        .ld_off    (off_reg),
        .ld_word   (dmem_rdata),
        .ld_data   (ld_ext)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            ctrl_reg   <= 3'b000;
            off_reg    <= 2'b00;
            cnt_reg    <= '0;
            done       <= 1'b0;
            fault      <= 1'b0;
            rdata      <= 32'h0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= 32'h0;
            dmem_be    <= 4'h0;
            dmem_wdata <= 32'h0;
        end else begin
            case (state_reg)
                IDLE: begin
                    done  <= 1'b0;
                    fault <= 1'b0;
                    rdata <= 32'h0;
                    cnt_reg <= '0;
                    if (op) begin
                        ctrl_reg <= memCtrl;
                        off_reg  <= addr[1:0];
                        if (issue_ok) begin
                            state_reg  <= BUS;
                            dmem_req   <= 1'b1;
                            dmem_we    <= issue_we;
                            dmem_addr  <= {addr[31:2], 2'b00};
                            dmem_be    <= be_comb;
                            dmem_wdata <= issue_we ? wrep_comb : 32'h0;
                        end else begin
                            state_reg <= DONE;
                            done      <= 1'b1;
                            fault     <= 1'b1;
                        end
                    end
                end
                BUS: begin
                    // An ack in the final allowed cycle still wins over the timeout.
                    if (dmem_ack || (TO_EN && cnt_reg == CNT_LAST)) begin
                        state_reg  <= DONE;
                        done       <= 1'b1;
                        fault      <= ~dmem_ack;
                        rdata      <= (dmem_ack && !dmem_we) ? ld_ext : 32'h0;
                        cnt_reg    <= '0;
                        dmem_req   <= 1'b0;
                        dmem_we    <= 1'b0;
                        dmem_addr  <= 32'h0;
                        dmem_be    <= 4'h0;
                        dmem_wdata <= 32'h0;
                    end else if (TO_EN) begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                    done      <= 1'b0;
                    fault     <= 1'b0;
                    rdata     <= 32'h0;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: one instance with a 4-cycle ack timeout, walked
// through loads, stores, faults, timeout and a mid-transaction reset.
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid, memRD, memWR;
    logic [2:0]  memCtrl;
    logic [31:0] addr, wdata;
    logic        stall, done, fault;
    logic [31:0] rdata;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;

    int n_checks = 0;
    int n_fail   = 0;
    int cnt;

    always #5 clk = ~clk;

    lsu #(.ACK_TIMEOUT(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .valid      (valid),
        .memRD      (memRD),
        .memWR      (memWR),
        .memCtrl    (memCtrl),
        .addr       (addr),
        .wdata      (wdata),
        .stall      (stall),
        .done       (done),
        .rdata      (rdata),
        .fault      (fault),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_be    (dmem_be),
        .dmem_wdata (dmem_wdata),
        .dmem_ack   (dmem_ack),
        .dmem_rdata (dmem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [2:0] ctrl,
                         input logic [31:0] a, input logic [31:0] d);
        valid = 1'b1; memRD = rd; memWR = wr; memCtrl = ctrl; addr = a; wdata = d;
    endtask

    task automatic idle();
        valid = 1'b0; memRD = 1'b0; memWR = 1'b0; memCtrl = 3'b000; addr = 32'h0; wdata = 32'h0;
    endtask

    // Load acked on its first request cycle; checks the extended result.
    task automatic do_load(input string tag, input logic [2:0] ctrl, input logic [31:0] a,
                           input logic [31:0] word, input logic [31:0] exp);
        @(negedge clk); drive(1'b1, 1'b0, ctrl, a, 32'h0); #1;
        $display("load %s ctrl=%b addr=%h word=%h", tag, ctrl, a, word);
        @(negedge clk); dmem_ack = 1'b1; dmem_rdata = word; #1;
        chk({tag, "_req"}, {31'h0, dmem_req}, 32'h1);
        chk({tag, "_we"}, {31'h0, dmem_we}, 32'h0);
        @(negedge clk); dmem_ack = 1'b0; #1;
        chk({tag, "_done"}, {31'h0, done}, 32'h1);
        chk({tag, "_rdata"}, rdata, exp);
        idle();
    endtask

    task automatic fault_case(input string tag, input logic rd, input logic wr,
                              input logic [2:0] ctrl, input logic [31:0] a);
        @(negedge clk); drive(rd, wr, ctrl, a, 32'h12345678); #1;
        $display("fault %s ctrl=%b addr=%h", tag, ctrl, a);
        chk({tag, "_req0"}, {31'h0, dmem_req}, 32'h0);
        chk({tag, "_stall0"}, {31'h0, stall}, 32'h1);
        @(negedge clk); #1;
        chk({tag, "_done"}, {31'h0, done}, 32'h1);
        chk({tag, "_fault"}, {31'h0, fault}, 32'h1);
        chk({tag, "_req1"}, {31'h0, dmem_req}, 32'h0);
        chk({tag, "_rdata"}, rdata, 32'h0);
        idle();
        @(negedge clk); #1;
        chk({tag, "_done_clr"}, {31'h0, done}, 32'h0);
    endtask

    initial begin
        rst = 1'b1; dmem_ack = 1'b0; dmem_rdata = 32'h0;
        idle();
        repeat (2) @(negedge clk);
        #1;
        $display("reset check");
        chk("rst_req", {31'h0, dmem_req}, 32'h0);
        chk("rst_we", {31'h0, dmem_we}, 32'h0);
        chk("rst_addr", dmem_addr, 32'h0);
        chk("rst_be", {28'h0, dmem_be}, 32'h0);
        chk("rst_wdata", dmem_wdata, 32'h0);
        chk("rst_done", {31'h0, done}, 32'h0);
        chk("rst_fault", {31'h0, fault}, 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        rst = 1'b0;

        // LB 0x1003, ack on the first request cycle
        @(negedge clk); drive(1'b1, 1'b0, 3'b000, 32'h1003, 32'h0); #1;
        $display("LB addr=00001003");
        chk("lb_stall0", {31'h0, stall}, 32'h1);
        chk("lb_req0", {31'h0, dmem_req}, 32'h0);
        @(negedge clk); #1;
        chk("lb_req1", {31'h0, dmem_req}, 32'h1);
        chk("lb_addr", dmem_addr, 32'h1000);
        chk("lb_we", {31'h0, dmem_we}, 32'h0);
        chk("lb_stall1", {31'h0, stall}, 32'h1);
        chk("lb_done1", {31'h0, done}, 32'h0);
        dmem_ack = 1'b1; dmem_rdata = 32'h80AA55CC;
        @(negedge clk); dmem_ack = 1'b0; #1;
        chk("lb_done2", {31'h0, done}, 32'h1);
        chk("lb_rdata", rdata, 32'hFFFFFF80);
        chk("lb_fault", {31'h0, fault}, 32'h0);
        chk("lb_stall2", {31'h0, stall}, 32'h0);
        chk("lb_req2", {31'h0, dmem_req}, 32'h0);
        idle();
        @(negedge clk); #1;
        chk("lb_done3", {31'h0, done}, 32'h0);
        chk("lb_rdata3", rdata, 32'h0);

        // LHU 0x2002 with three wait cycles
        @(negedge clk); drive(1'b1, 1'b0, 3'b100, 32'h2002, 32'h0); #1;
        $display("LHU addr=00002002 ack after 3 waits");
        cnt = stall ? 1 : 0;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            dmem_ack = (c == 4); dmem_rdata = 32'h80011234; #1;
            if (stall) cnt++;
            if (c < 5) chk("lhu_done_early", {31'h0, done}, 32'h0);
        end
        chk("lhu_done", {31'h0, done}, 32'h1);
        chk("lhu_rdata", rdata, 32'h00008001);
        chk("lhu_fault", {31'h0, fault}, 32'h0);
        chk("lhu_stall_cycles", cnt, 32'd5);
        dmem_ack = 1'b0;
        idle();

        // SB 0x11
        @(negedge clk); drive(1'b0, 1'b1, 3'b101, 32'h11, 32'h000000AB); #1;
        $display("SB addr=00000011 wdata=000000ab");
        @(negedge clk); #1;
        chk("sb_req", {31'h0, dmem_req}, 32'h1);
        chk("sb_addr", dmem_addr, 32'h10);
        chk("sb_be", {28'h0, dmem_be}, 32'h2);
        chk("sb_wdata", dmem_wdata, 32'hABABABAB);
        chk("sb_we", {31'h0, dmem_we}, 32'h1);
        dmem_ack = 1'b1; dmem_rdata = 32'hFFFFFFFF;
        @(negedge clk); dmem_ack = 1'b0; #1;
        chk("sb_done", {31'h0, done}, 32'h1);
        chk("sb_rdata", rdata, 32'h0);
        chk("sb_fault", {31'h0, fault}, 32'h0);
        idle();

        // SW 0x20
        @(negedge clk); drive(1'b0, 1'b1, 3'b111, 32'h20, 32'hDEADBEEF); #1;
        $display("SW addr=00000020 wdata=deadbeef");
        @(negedge clk); #1;
        chk("sw_be", {28'h0, dmem_be}, 32'hF);
        chk("sw_wdata", dmem_wdata, 32'hDEADBEEF);
        chk("sw_addr", dmem_addr, 32'h20);
        dmem_ack = 1'b1;
        @(negedge clk); dmem_ack = 1'b0; #1;
        chk("sw_done", {31'h0, done}, 32'h1);
        idle();

        // SH with both bits of the read-modify-free half lane
        @(negedge clk); drive(1'b0, 1'b1, 3'b110, 32'h36, 32'h0000BEEF); #1;
        $display("SH addr=00000036 wdata=0000beef");
        @(negedge clk); #1;
        chk("sh_be", {28'h0, dmem_be}, 32'hC);
        chk("sh_wdata", dmem_wdata, 32'hBEEFBEEF);
        dmem_ack = 1'b1;
        @(negedge clk); dmem_ack = 1'b0; #1;
        chk("sh_done", {31'h0, done}, 32'h1);
        idle();

        fault_case("lw_mis", 1'b1, 1'b0, 3'b010, 32'h102);
        fault_case("sh_mis", 1'b0, 1'b1, 3'b110, 32'h7);
        fault_case("st_ill", 1'b0, 1'b1, 3'b000, 32'h40);

        do_load("lh", 3'b001, 32'h6, 32'h80011234, 32'hFFFF8001);
        do_load("lbu", 3'b011, 32'h9, 32'h0000F100, 32'h000000F1);

        // Timeout with ack held low, then a late ack
        @(negedge clk); drive(1'b1, 1'b0, 3'b010, 32'h40, 32'h0); #1;
        $display("LW addr=00000040 timeout");
        cnt = 0;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk); #1;
            if (dmem_req) cnt++;
        end
        chk("to_req_cycles", cnt, 32'd4);
        chk("to_done", {31'h0, done}, 32'h1);
        chk("to_fault", {31'h0, fault}, 32'h1);
        chk("to_rdata", rdata, 32'h0);
        idle();
        dmem_ack = 1'b1; dmem_rdata = 32'h55555555;
        @(negedge clk); #1;
        chk("late_req", {31'h0, dmem_req}, 32'h0);
        chk("late_done", {31'h0, done}, 32'h0);
        dmem_ack = 1'b0;
        @(negedge clk); #1;
        chk("late_done2", {31'h0, done}, 32'h0);
        chk("late_rdata", rdata, 32'h0);

        // Asynchronous reset during BUS
        @(negedge clk); drive(1'b1, 1'b0, 3'b010, 32'h80, 32'h0); #1;
        $display("LW addr=00000080 reset in BUS");
        @(negedge clk); #1;
        chk("ar_req_before", {31'h0, dmem_req}, 32'h1);
        rst = 1'b1; #1;
        chk("ar_req_async", {31'h0, dmem_req}, 32'h0);
        chk("ar_addr_async", dmem_addr, 32'h0);
        idle();
        #1 rst = 1'b0;
        @(negedge clk); #1;
        chk("ar_done", {31'h0, done}, 32'h0);
        do_load("ar_next", 3'b000, 32'h4, 32'h0000007F, 32'h0000007F);

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
